// File: rtl/alu_rr_sched_if.sv
// Client-side bus of alu_rr_sched: packed request/operand vectors in, grant and response strobes out.
// The master modport belongs to the requester side; the slave modport belongs to the scheduler.
interface alu_rr_sched_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] req_op;
  logic [4*NREQ-1:0] req_a;
  logic [4*NREQ-1:0] req_b;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic [NREQ-1:0]   rsp_valid;
  logic [3:0]        rsp_res;
  logic              rsp_err;

  modport master (
    output req, req_op, req_a, req_b,
    input  gnt, busy, rsp_valid, rsp_res, rsp_err
  );

  modport slave (
    input  req, req_op, req_a, req_b,
    output gnt, busy, rsp_valid, rsp_res, rsp_err
  );
endinterface

// File: rtl/alu_rr_sched.sv
// Round-robin scheduler that shares one combinational 4-bit ALU between NREQ requesters.
// Optional macro ALU_SCHED_DIVZ_CHK_EN: flag divide/modulo by zero with rsp_err and force the result to 0.
module alu_rr_sched #(
  parameter int NREQ = 4,
  parameter int IDXW = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_rr_sched_if.slave      cli,
  output logic [3:0]         alu_op,
  output logic [3:0]         alu_a,
  output logic [3:0]         alu_b,
  input  logic [3:0]         alu_res
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [IDXW-1:0] PTR_RST = IDXW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE_OH  = {{(NREQ-1){1'b0}}, 1'b1};

  state_e          state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [IDXW-1:0] win_q, win_d;
  logic [3:0]      alu_op_q, alu_op_d;
  logic [3:0]      alu_a_q, alu_a_d;
  logic [3:0]      alu_b_q, alu_b_d;
  logic [3:0]      rsp_res_q, rsp_res_d;
  logic            rsp_err_q, rsp_err_d;

  logic            found;
  logic [IDXW-1:0] win_idx;
  logic            divz;

  // Search starts one past the last winner and wraps, so each requester gets a turn.
  always_comb begin
    int idx;
    found   = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && cli.req[idx]) begin
        found   = 1'b1;
        win_idx = IDXW'(idx);
      end
    end
  end

`ifdef ALU_SCHED_DIVZ_CHK_EN
  assign divz = ((alu_op_q == 4'b0011) || (alu_op_q == 4'b0100)) && (alu_b_q == 4'd0);
`else
  assign divz = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    alu_op_d  = alu_op_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    rsp_res_d = rsp_res_q;
    rsp_err_d = rsp_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          alu_op_d = cli.req_op[4*int'(win_idx) +: 4];
          alu_a_d  = cli.req_a[4*int'(win_idx) +: 4];
          alu_b_d  = cli.req_b[4*int'(win_idx) +: 4];
          win_d    = win_idx;
          ptr_d    = win_idx;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_res_d = divz ? 4'd0 : alu_res;
        rsp_err_d = divz;
        state_d   = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= PTR_RST;
      win_q     <= '0;
      alu_op_q  <= 4'b0000;
      alu_a_q   <= 4'd0;
      alu_b_q   <= 4'd0;
      rsp_res_q <= 4'd0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      alu_op_q  <= alu_op_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      rsp_res_q <= rsp_res_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign cli.gnt       = (state_q == ST_IDLE && found) ? (ONE_OH << win_idx) : '0;
  assign cli.busy      = (state_q != ST_IDLE);
  assign cli.rsp_valid = (state_q == ST_RESP) ? (ONE_OH << win_q) : '0;
  assign cli.rsp_res   = rsp_res_q;
  assign cli.rsp_err   = rsp_err_q;
  assign alu_op        = alu_op_q;
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;

endmodule
